// File: rtl/fft8_out_reorder.sv
// ---------------------------------------------------------------------------
// fft8_out_reorder
//
// Sits behind the 8-point FFT. It captures two bins per accepted cycle (X1/X2,
// bit-reversed pair order) into one bank of a ping-pong buffer. It then
// re-emits each completed frame serially, one bin per clock, in natural order
// 0..7. Sustains one frame per 8 clocks. A frame start into a still-full bank
// is dropped and raises a sticky overrun flag.
//
// Ports
//   c          : clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_en      : pair-valid strobe from the FFT stage
//   X1r/X1i    : first bin of the pair  (bin br(2k))
//   X2r/X2i    : second bin of the pair (bin br(2k+1))
//   in_ready   : the current write bank can take a new frame start
//   out_valid  : out_re/out_im carry a bin
//   out_first  : high with bin 0 of each frame
//   out_idx    : natural-order index of the bin being output
//   out_re/im  : bin value; holds its last value while out_valid is low
//   ovf        : sticky overrun flag, cleared only by rst
// ---------------------------------------------------------------------------
module fft8_out_reorder #(
  parameter int W = 16
) (
  input  logic                c,
  input  logic                rst,
  input  logic                in_en,
  input  logic signed [W-1:0] X1r,
  input  logic signed [W-1:0] X1i,
  input  logic signed [W-1:0] X2r,
  input  logic signed [W-1:0] X2i,
  output logic                in_ready,
  output logic                out_valid,
  output logic                out_first,
  output logic [2:0]          out_idx,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                ovf
);

  typedef enum logic {IDLE, READ} rd_state_e;

  // Write side
  logic [1:0] wptr_q, wptr_d;
  logic       wbank_q, wbank_d;
  logic [1:0] full_q, full_d;
  logic       ovf_q, ovf_d;
  logic       blocked, accept, frame_done;
  logic [2:0] bin_lo, bin_hi;

  // Read side
  rd_state_e  state_q, state_d;
  logic       rbank_q, rbank_d;
  logic [2:0] rptr_q, rptr_d;
  logic       emit, clr;

  // Output registers
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic [2:0]          out_idx_q, out_idx_d;
  logic signed [W-1:0] out_re_q, out_re_d;
  logic signed [W-1:0] out_im_q, out_im_d;

  // Storage, addressed {bank, bin}.
  logic signed [W-1:0] mem_re_q [16];
  logic signed [W-1:0] mem_im_q [16];

  // ---------------------------------------------------------------------------
  // Write control
  // ---------------------------------------------------------------------------
  always_comb begin
    // Only a frame start checks for a full bank. Mid-frame the bank is ours.
    blocked    = (wptr_q == 2'd0) && full_q[wbank_q];
    accept     = in_en && !blocked;
    frame_done = accept && (wptr_q == 2'd3);
    // Pair k carries br(2k) and br(2k+1). br({k1,k0,b0}) = {b0,k0,k1}.
    bin_lo     = {1'b0, wptr_q[0], wptr_q[1]};
    bin_hi     = {1'b1, wptr_q[0], wptr_q[1]};

    wptr_d  = accept ? wptr_q + 2'd1 : wptr_q;
    wbank_d = frame_done ? ~wbank_q : wbank_q;
    ovf_d   = ovf_q | (in_en & blocked);
  end

  // NOTE: the sample buffer has no reset. The full flags alone decide what is
  // valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge c) begin
    if (accept) begin
      mem_re_q[{wbank_q, bin_lo}] <= X1r;
      mem_im_q[{wbank_q, bin_lo}] <= X1i;
      mem_re_q[{wbank_q, bin_hi}] <= X2r;
      mem_im_q[{wbank_q, bin_hi}] <= X2i;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. Banks fill and drain in strict alternation, so rbank_q always
  // names the oldest full bank. A full rbank is emitted from immediately, so
  // bin 0 leaves one edge after the frame completes, even from IDLE.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    rbank_d = rbank_q;
    clr     = 1'b0;
    emit    = full_q[rbank_q];

    unique case (state_q)
      IDLE: if (emit) state_d = READ;
      READ: ;
      default: state_d = IDLE;
    endcase

    if (emit) begin
      rptr_d = rptr_q + 3'd1;
      if (rptr_q == 3'd7) begin
        clr     = 1'b1;
        rbank_d = ~rbank_q;
        // A bank filling on this same edge is seen next cycle from IDLE.
        // It still goes out with no gap.
        state_d = full_q[~rbank_q] ? READ : IDLE;
      end
    end

    // Set and clear never hit the same bank. A bank being written is not full.
    full_d = full_q;
    if (clr)        full_d[rbank_q] = 1'b0;
    if (frame_done) full_d[wbank_q] = 1'b1;

    out_valid_d = emit;
    out_first_d = emit && (rptr_q == 3'd0);
    out_idx_d   = emit ? rptr_q : 3'd0;
    out_re_d    = emit ? mem_re_q[{rbank_q, rptr_q}] : out_re_q;
    out_im_d    = emit ? mem_im_q[{rbank_q, rptr_q}] : out_im_q;
  end

  // NOTE: state uses non-blocking assignments. Every register then samples
  // pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      wptr_q      <= 2'd0;
      wbank_q     <= 1'b0;
      full_q      <= 2'b00;
      ovf_q       <= 1'b0;
      state_q     <= IDLE;
      rbank_q     <= 1'b0;
      rptr_q      <= 3'd0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_idx_q   <= 3'd0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      wbank_q     <= wbank_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign in_ready  = ~full_q[wbank_q];
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_idx   = out_idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft8_out_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft8_out_reorder
//
// Scoreboard bench for fft8_out_reorder. Each frame pushes its 8 expected bins
// when its last pair is driven. Each entry is tagged with the edge it must
// appear on, so latency and back-to-back spacing are checked as well as data.
// ---------------------------------------------------------------------------
module tb_fft8_out_reorder;

  localparam int W = 16;

  logic                c = 1'b0;
  logic                rst = 1'b1;
  logic                in_en = 1'b0;
  logic signed [W-1:0] X1r = '0, X1i = '0, X2r = '0, X2i = '0;
  logic                in_ready, out_valid, out_first, ovf;
  logic [2:0]          out_idx;
  logic signed [W-1:0] out_re, out_im;

  fft8_out_reorder #(.W(W)) dut (
    .c         (c),
    .rst       (rst),
    .in_en     (in_en),
    .X1r       (X1r),
    .X1i       (X1i),
    .X2r       (X2r),
    .X2i       (X2i),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_idx   (out_idx),
    .out_re    (out_re),
    .out_im    (out_im),
    .ovf       (ovf)
  );

  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  typedef struct {
    int                  at_cyc;
    logic [2:0]          idx;
    logic                first;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } exp_t;

  exp_t                sb_q[$];
  int                  n_checks = 0;
  int                  n_fail = 0;
  int                  last_edge = 0;
  logic signed [W-1:0] last_re = '0, last_im = '0;
  logic signed [W-1:0] fr_re [8];
  logic signed [W-1:0] fr_im [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int br3(input int x);
    return {29'd0, x[0], x[1], x[2]};
  endfunction

  function automatic void set_ramp(input int base);
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = W'(base + b);
      fr_im[b] = W'(-b);
    end
  endfunction

  // Drive one frame as 4 pairs. gap inserts idle cycles between pair k1 and
  // pair k2. Then schedule its 8 bins in the scoreboard.
  task automatic send_frame(input int gap);
    int n, start;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) check("in_ready_start", in_ready, 1'b1);
      in_en = 1'b1;
      X1r = fr_re[br3(2*k)];   X1i = fr_im[br3(2*k)];
      X2r = fr_re[br3(2*k+1)]; X2i = fr_im[br3(2*k+1)];
      @(posedge c); #1;
      in_en = 1'b0;
      if (k == 1 && gap > 0) begin
        repeat (gap) @(posedge c);
        #1;
      end
    end
    n = cyc;
    start = (n + 1 > last_edge + 1) ? n + 1 : last_edge + 1;
    for (int b = 0; b < 8; b++)
      sb_q.push_back('{at_cyc: start + b, idx: 3'(b), first: (b == 0),
                       re: fr_re[b], im: fr_im[b]});
    last_edge = start + 7;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge c);
    repeat (3) @(posedge c);
    #1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge c) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("latency", cyc, e.at_cyc);
          check("out_idx", out_idx, e.idx);
          check("out_first", out_first, e.first);
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          last_re = e.re;
          last_im = e.im;
        end
      end else begin
        check("idle_first", out_first, 1'b0);
        check("idle_idx", out_idx, 3'd0);
        check("hold_re", out_re, last_re);
        check("hold_im", out_im, last_im);
        if (sb_q.size() != 0 && sb_q[0].at_cyc <= cyc)
          check("missing_valid", out_valid, 1'b1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset state
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_first", out_first, 1'b0);
    check("rst_idx", out_idx, 3'd0);
    check("rst_re", out_re, 16'd0);
    check("rst_im", out_im, 16'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge c); #1;
    rst = 1'b0;
    repeat (2) @(posedge c);
    #1;

    // One frame from an idle reader
    set_ramp(100);
    send_frame(0);
    drain();
    check("ovf_clean", ovf, 1'b0);

    // Two frames back-to-back, then a third starting into a still-full bank
    set_ramp(100);
    send_frame(0);
    set_ramp(200);
    send_frame(0);
    check("in_ready_busy", in_ready, 1'b0);
    in_en = 1'b1;
    X1r = 16'sd999; X1i = 16'sd999; X2r = 16'sd999; X2i = 16'sd999;
    @(posedge c); #1;
    in_en = 1'b0;
    check("ovf_set", ovf, 1'b1);
    drain();
    check("ovf_sticky", ovf, 1'b1);

    // Stall of 3 cycles mid-frame
    set_ramp(100);
    send_frame(3);
    drain();

    // Full-scale values pass bit-exact
    for (int b = 0; b < 8; b++) begin
      fr_re[b] = b[0] ? 16'sh8000 : 16'sh7FFF;
      fr_im[b] = b[0] ? 16'sh7FFF : 16'sh8000;
    end
    send_frame(0);
    drain();

    // Reset mid-read at bin 3
    set_ramp(300);
    send_frame(0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_idx == 3'd3) found = 1'b1;
      else begin
        @(posedge c); #1;
      end
    end
    check("reach_bin3", found, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_idx", out_idx, 3'd0);
    check("mid_rst_re", out_re, 16'd0);
    check("mid_rst_im", out_im, 16'd0);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    sb_q.delete();
    last_re = '0;
    last_im = '0;
    last_edge = 0;
    repeat (2) @(posedge c);
    #1;
    rst = 1'b0;
    @(posedge c); #1;
    set_ramp(100);
    send_frame(0);
    drain();
    check("ovf_after_rst", ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
